fetch_unit: RTL and testbench

Instruction-fetch stage that produces the instruction/PC pair consumed by the decode stage. It also consumes decode's redirect outputs: stall, jump_branch, jump_target, jump_reg, jr_pc and branch_offset. It owns the PC, issues word requests to instruction memory over a valid/ready request and valid response interface, and buffers one returned instruction while decode stalls. It implements the MIPS single branch-delay-slot redirect.

---
 rtl/fetch_unit_pkg.sv | 5 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_target_calc.sv | 16 +
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM state encodings and the NOP bubble constant
package fetch_unit_pkg;
  typedef enum logic [1:0] {FETCH_ISSUE = 2'd0, FETCH_WAIT = 2'd1, FETCH_FULL = 2'd2} fetch_state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem valid/ready request (req_valid, req_ready, addr) and valid response (resp_valid, resp_data)
interface fetch_unit_if;
  logic req_valid;
  logic req_ready;
  logic [31:0] addr;
  logic resp_valid;
  logic [31:0] resp_data;
  modport master(output req_valid, addr, input req_ready, resp_valid, resp_data);
  modport slave(input req_valid, addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: redirect target from pc_id/instr_id/jr_pc/branch_offset, priority jump_reg > jump_target > branch
module fetch_target_calc (
  input  logic [31:0] pc_id,
  input  logic [31:0] instr_id,
  input  logic [31:0] jr_pc,
  input  logic [31:0] branch_offset,
  input  logic        jump_target,
  input  logic        jump_reg,
  output logic [31:0] target
);
  logic [31:0] pc4;
  assign pc4 = pc_id + 32'd4;
  assign target = jump_reg ? (jr_pc & ~32'd3) :
                  jump_target ? ((pc4 & 32'hF000_0000) | ((instr_id << 2) & 32'h0FFF_FFFC)) :
                  pc4 + branch_offset;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage (clk, rst active-low, imem master, decode redirects in, instr_id/pc_id/id_valid out)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         jump_branch,
  input  logic         jump_target,
  input  logic         jump_reg,
  input  logic [31:0]  jr_pc,
  input  logic [31:0]  branch_offset,
  output logic [31:0]  instr_id,
  output logic [31:0]  pc_id,
  output logic         id_valid
);
  fetch_state_t state, state_nxt;
  logic [31:0] npc, pc_req, tgt, buf_data, new_instr, target;
  logic ds_pending, id_free, accept, have_new, redirect;
  fetch_target_calc u_target (
    .pc_id(pc_id),
    .instr_id(instr_id),
    .jr_pc(jr_pc),
    .branch_offset(branch_offset),
    .jump_target(jump_target),
    .jump_reg(jump_reg),
    .target(target)
  );
  always_comb begin
    id_free = ~id_valid | ~stall;
    accept = state == FETCH_ISSUE && imem.req_ready;
    have_new = state == FETCH_FULL || (state == FETCH_WAIT && imem.resp_valid);
    new_instr = state == FETCH_FULL ? buf_data : imem.resp_data;
    redirect = id_valid & ~stall & (jump_target | jump_branch);
    imem.req_valid = rst && state == FETCH_ISSUE;
    imem.addr = npc;
    state_nxt = state == FETCH_ISSUE ? (imem.req_ready ? FETCH_WAIT : FETCH_ISSUE) :
                state == FETCH_WAIT  ? (imem.resp_valid ? (id_free ? FETCH_ISSUE : FETCH_FULL) : FETCH_WAIT) :
                (id_free ? FETCH_ISSUE : FETCH_FULL);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH_ISSUE;
      npc <= RESET_PC;
      pc_req <= '0;
      tgt <= '0;
      buf_data <= NOP;
      ds_pending <= 1'b0;
      instr_id <= NOP;
      pc_id <= '0;
      id_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_req <= npc;
        npc <= ds_pending ? tgt : npc + 32'd4;
        ds_pending <= 1'b0;
      end
      if (redirect) begin
        if (pc_req == pc_id + 32'd4 || accept) npc <= target;
        else begin
          ds_pending <= 1'b1;
          tgt <= target;
        end
      end
      if (state == FETCH_WAIT && imem.resp_valid && !id_free) buf_data <= imem.resp_data;
      if (id_free) begin
        instr_id <= have_new ? new_instr : NOP;
        id_valid <= have_new;
        if (have_new) pc_id <= pc_req;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench with an architectural-PC scoreboard and a latency-randomized imem model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 0, stall = 0, jump_branch = 0, jump_target = 0, jump_reg = 0;
  logic [31:0] jr_pc = '0, branch_offset = '0, instr_id, pc_id;
  logic id_valid;
  fetch_unit_if imem();
  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imem(imem),
    .stall(stall),
    .jump_branch(jump_branch),
    .jump_target(jump_target),
    .jump_reg(jump_reg),
    .jr_pc(jr_pc),
    .branch_offset(branch_offset),
    .instr_id(instr_id),
    .pc_id(pc_id),
    .id_valid(id_valid)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0, deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = '0;
  logic out = 0, prev_wait = 0, pend = 0;
  int cnt = 0;
  logic [31:0] oaddr = '0, prev_addr = '0, ptgt = '0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step();
    logic [31:0] r, pc4, ins;
    int kind;
    @(negedge clk);
    imem.resp_valid = 0;
    if (out) begin
      if (cnt == 0) begin
        imem.resp_valid = 1;
        imem.resp_data = mem(oaddr);
        out = 0;
      end else cnt--;
    end
    if (prev_wait) begin
      chk("req_hold_valid", {31'b0, imem.req_valid}, 1);
      chk("req_hold_addr", imem.addr, prev_addr);
    end
    imem.req_ready = ($urandom % 3) != 0;
    prev_wait = imem.req_valid && !imem.req_ready;
    prev_addr = imem.addr;
    if (imem.req_valid && imem.req_ready) begin
      chk("one_outstanding", {31'b0, out}, 0);
      out = 1;
      cnt = $urandom_range(0, 2);
      oaddr = imem.addr;
    end
    stall = ($urandom % 5) < 2;
    jump_branch = 0;
    jump_target = 0;
    jump_reg = 0;
    jr_pc = $urandom;
    branch_offset = $urandom;
    if (id_valid && !stall) begin
      if (pend) begin
        exp_q.push_back(ptgt);
        pend = 0;
      end else begin
        exp_q.push_back(cur_pc + 32'd4);
        if ($urandom % 3 == 0) begin
          kind = $urandom % 3;
          pc4 = cur_pc + 32'd4;
          r = $urandom;
          pend = 1;
          if (kind == 0) begin
            jump_branch = 1;
            branch_offset = {{14{r[17]}}, r[17:2], 2'b00};
            ptgt = pc4 + branch_offset;
          end else if (kind == 1) begin
            jump_target = 1;
            jump_branch = r[0];
            ins = mem(cur_pc);
            ptgt = {pc4[31:28], ins[25:0], 2'b00};
          end else begin
            jump_target = 1;
            jump_reg = 1;
            jump_branch = r[0];
            jr_pc = (r[5:4] == 2'b00) ? 32'hFFFF_FFF9 : $urandom;
            ptgt = {jr_pc[31:2], 2'b00};
          end
        end
      end
    end else if ($urandom % 3 == 0) begin
      r = $urandom;
      jump_branch = r[0];
      jump_target = r[1];
      jump_reg = r[2];
    end
  endtask
  initial begin
    logic pv;
    logic [31:0] e;
    pv = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        chk("rst_id_valid", {31'b0, id_valid}, 0);
        chk("rst_instr_id", instr_id, NOP);
        chk("rst_pc_id", pc_id, 0);
        chk("rst_req_valid", {31'b0, imem.req_valid}, 0);
        pv = 0;
      end else begin
        if (id_valid && !(pv && stall)) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_delivery: got pc %h expected none", pc_id);
          end else begin
            e = exp_q.pop_front();
            chk("pc_id", pc_id, e);
            chk("instr_id", instr_id, mem(e));
            cur_pc = e;
            deliveries++;
          end
        end
        pv = id_valid;
      end
    end
  end
  initial begin
    int guard;
    imem.req_ready = 0;
    imem.resp_valid = 0;
    imem.resp_data = '0;
    exp_q.push_back(RPC);
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2000) step();
    guard = 0;
    while ((imem.req_valid || id_valid) && guard < 200) begin
      step();
      guard++;
    end
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    exp_q.push_back(RPC);
    pend = 0;
    out = 0;
    prev_wait = 0;
    imem.resp_valid = 0;
    stall = 0;
    jump_branch = 0;
    jump_target = 0;
    jump_reg = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (2000) step();
    @(negedge clk);
    chk("progress", {31'b0, deliveries > 300}, 1);
    chk("queue_len", {31'b0, exp_q.size() <= 1}, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
